fetch_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS cpu; first stage, feeds decode.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if_id_reg.sv | 75 +++++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared constants and types for the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam int          CLOCK_PERIOD     = 10;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
//  Module      : fetch_stage_if_id_reg
//  Description : IF/ID pipeline register; holds on stall, flush inserts a bubble.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage_if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] if_instr,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [ADDR_W-1:0] if_pc_plus4,
   output logic              id_valid,
   output logic [DATA_W-1:0] id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc_plus4
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic              enable;

   // Flush overrides stall so a squash is never lost behind a hazard hold.
   assign enable = ~stall | flush;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      if (enable) begin
         if (flush) begin
            valid_d = 1'b0;
            instr_d = DATA_W'(NOP_INSTR);
         end else begin
            valid_d = 1'b1;
            instr_d = if_instr;
            pc_d    = if_pc;
            pc4_d   = if_pc_plus4;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= DATA_W'(NOP_INSTR);
         pc_q    <= '0;
         pc4_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
      end
   end

   assign id_valid    = valid_q;
   assign id_instr    = instr_q;
   assign id_pc       = pc_q;
   assign id_pc_plus4 = pc4_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS instruction fetch: PC, run/halt FSM, fetch counter, IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              id_valid,
   output logic [DATA_W-1:0] id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc_plus4,
   output logic              halted,
   output logic              misalign_err,
   output logic [31:0]       fetch_count
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       count_q, count_d;
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_aligned;
   logic              do_redirect;
   logic              do_idle;
   logic              do_fetch;
   logic              flush;

   assign pc_plus4         = pc_q + ADDR_W'(PC_STEP);
   assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (halt_req) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   // A halt request without a concurrent redirect already behaves like HALT
   // on its own edge, so the PC never advances past the halting address.
   always_comb begin
      do_redirect = 1'b0;
      do_idle     = 1'b1;
      do_fetch    = 1'b0;
      halted      = 1'b1;
      if (state_q == ST_RUN) begin
         halted      = 1'b0;
         do_redirect = redirect;
         do_idle     = ~redirect & halt_req;
         do_fetch    = ~redirect & ~halt_req & ~stall;
      end
      flush = do_redirect | (do_idle & ~stall);
   end

   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      misalign_d = misalign_q;
      if (do_redirect) begin
         pc_d       = redirect_aligned;
         misalign_d = misalign_q | is_misaligned(redirect_pc[1:0]);
      end else if (do_fetch) begin
         pc_d    = pc_plus4;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         count_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr    = pc_q;
   assign fetch_count  = count_q;
   assign misalign_err = misalign_q;

   fetch_stage_if_id_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_if_id_reg (
      .clock       (clock),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .if_instr    (imem_rdata),
      .if_pc       (pc_q),
      .if_pc_plus4 (pc_plus4),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4)
   );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed scenarios plus randomized traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        halted;
   logic        misalign_err;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_count;
   logic        m_valid, m_halted, m_mis;

   fetch_stage #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .halt_req     (halt_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_pc_plus4  (id_pc_plus4),
      .halted       (halted),
      .misalign_err (misalign_err),
      .fetch_count  (fetch_count)
   );

   assign imem_rdata = mem[imem_addr[7:2]];

   initial begin
      clock = 1'b0;
      forever #(CLOCK_PERIOD / 2) clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = 32'h0;
      m_halted = 1'b0;
      m_valid  = 1'b0;
      m_instr  = 32'h0;
      m_id_pc  = 32'h0;
      m_id_pc4 = 32'h0;
      m_mis    = 1'b0;
      m_count  = 32'h0;
   endtask

   task automatic model_bubble();
      m_valid = 1'b0;
      m_instr = 32'h0;
   endtask

   // One clock edge of the fetch stage, written from the behavioural rules.
   task automatic model_step();
      if (m_halted) begin
         if (!stall) model_bubble();
      end else if (redirect) begin
         m_pc  = {redirect_pc[31:2], 2'b00};
         m_mis = m_mis | (redirect_pc[1:0] != 2'b00);
         model_bubble();
         if (halt_req) m_halted = 1'b1;
      end else if (halt_req) begin
         m_halted = 1'b1;
         if (!stall) model_bubble();
      end else if (!stall) begin
         m_valid  = 1'b1;
         m_instr  = mem[m_pc[7:2]];
         m_id_pc  = m_pc;
         m_id_pc4 = m_pc + 32'd4;
         m_pc     = m_pc + 32'd4;
         m_count  = m_count + 32'd1;
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, ":imem_addr"},   imem_addr,           m_pc);
      check({ph, ":id_valid"},    {31'b0, id_valid},   {31'b0, m_valid});
      check({ph, ":id_instr"},    id_instr,            m_instr);
      check({ph, ":id_pc"},       id_pc,               m_id_pc);
      check({ph, ":id_pc_plus4"}, id_pc_plus4,         m_id_pc4);
      check({ph, ":halted"},      {31'b0, halted},     {31'b0, m_halted});
      check({ph, ":misalign"},    {31'b0, misalign_err}, {31'b0, m_mis});
      check({ph, ":fetch_count"}, fetch_count,         m_count);
   endtask

   task automatic cycle(input string ph);
      @(posedge clock);
      model_step();
      #1;
      check_all(ph);
   endtask

   // Reset is raised away from any edge so the asynchronous path is observed.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clock);
      #1;
      check_all("rst_hold");
      reset = 1'b0;
   endtask

   task automatic set_in(input logic s, input logic r, input logic [31:0] rpc, input logic h);
      stall       = s;
      redirect    = r;
      redirect_pc = rpc;
      halt_req    = h;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h2010_0009;
      mem[1] = 32'h2011_0001;
      mem[2] = 32'h0;
      mem[3] = 32'h0;
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      #3;
      do_reset();
      check("t1_reset_pc", imem_addr, 32'h0);

      // straight-line fetch from address 0
      for (int k = 0; k < 4; k++) begin
         cycle("t1");
         check("t1_id_pc", id_pc, 32'(k * 4));
         if (k == 0) check("t1_instr0", id_instr, 32'h2010_0009);
         if (k == 1) check("t1_instr1", id_instr, 32'h2011_0001);
      end
      check("t1_count", fetch_count, 32'd4);

      // hazard stall holds PC and IF/ID
      do_reset();
      cycle("t2");
      cycle("t2");
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle("t2_stall");
         check("t2_addr", imem_addr, 32'h8);
         check("t2_id_pc", id_pc, 32'h4);
         check("t2_count", fetch_count, 32'd2);
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      cycle("t2_rel");
      check("t2_rel_id_pc", id_pc, 32'h8);

      // redirect wins over stall
      set_in(1'b1, 1'b1, 32'h40, 1'b0);
      cycle("t3");
      check("t3_addr", imem_addr, 32'h40);
      check("t3_valid", {31'b0, id_valid}, 32'h0);
      check("t3_instr", id_instr, 32'h0);
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      cycle("t3_next");
      check("t3_id_pc", id_pc, 32'h40);

      // misaligned target is aligned down and flagged stickily
      set_in(1'b0, 1'b1, 32'h42, 1'b0);
      cycle("t4");
      check("t4_addr", imem_addr, 32'h40);
      check("t4_mis", {31'b0, misalign_err}, 32'h1);
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) cycle("t4_hold");
      check("t4_mis_sticky", {31'b0, misalign_err}, 32'h1);

      // halt freezes fetch; only reset leaves HALT
      do_reset();
      for (int k = 0; k < 4; k++) cycle("t5_run");
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      cycle("t5_halt");
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      check("t5_halted", {31'b0, halted}, 32'h1);
      check("t5_addr", imem_addr, 32'h10);
      check("t5_valid", {31'b0, id_valid}, 32'h0);
      set_in(1'b0, 1'b1, 32'h80, 1'b0);
      cycle("t5_redir");
      check("t5_redir_ign", imem_addr, 32'h10);
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      do_reset();
      check("t5_rst_halted", {31'b0, halted}, 32'h0);
      cycle("t5_after");
      check("t5_run_again", {31'b0, id_valid}, 32'h1);

      // PC wrap and reset during a stall
      set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      cycle("t6");
      check("t6_addr", imem_addr, 32'hFFFF_FFFC);
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      cycle("t6_wrap");
      check("t6_wrap_addr", imem_addr, 32'h0);
      check("t6_wrap_pc4", id_pc_plus4, 32'h0);
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      cycle("t6_stall");
      cycle("t6_stall");
      do_reset();
      check("t6_rst_count", fetch_count, 32'h0);
      set_in(1'b0, 1'b0, 32'h0, 1'b0);

      // randomized traffic
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            set_in($urandom_range(0, 3) == 0,
                   $urandom_range(0, 9) == 0,
                   ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom)},
                   $urandom_range(0, 59) == 0);
            cycle("rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
